uart_param_core: RTL and testbench

Parametrised full-duplex UART core that replaces the fixed 8N1 transceiver inside top_uart. It provides a configurable frame format (data bits, parity, stop bits), a valid/ready transmit handshake, and an oversampled receiver with start-bit validation and error flags. It sits between the keypad/LED glue logic and the external tx/rx pins, clocked at 27 MHz.

---
 rtl/uart_param_core_if.sv | 26 ++
 rtl/uart_param_core.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_uart_param_core.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_param_core_if.sv
// uart_param_core_if: parallel-side bundle of the UART core.
//   tx_data/tx_valid/tx_ready : transmit valid/ready handshake
//   rx_data/rx_valid          : received payload plus one-cycle completion pulse
//   rx_frame_err/rx_parity_err: error flags, meaningful only while rx_valid=1
// The "master" modport is the user side, "slave" is the core side.
interface uart_param_core_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_frame_err;
  logic                 rx_parity_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, rx_frame_err, rx_parity_err
  );
endinterface

// File: rtl/uart_param_core.sv
// uart_param_core: parametrised full-duplex UART (data bits, parity, stop bits).
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset; aborts any frame in flight
//   bus  : uart_param_core_if.slave (tx handshake, rx payload and flags)
//   tx   : serial output, idles high
//   rx   : serial input, asynchronous to clk
module uart_param_core #(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  uart_param_core_if.slave  bus,
  output logic              tx,
  input  logic              rx
);
  localparam int DIV      = (CLK_FREQ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int BIT_CLKS = DIV * OVERSAMPLE;
  localparam int DIV_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W    = $clog2(BIT_CLKS);
  localparam int OS_W     = $clog2(OVERSAMPLE);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_param_core: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_param_core: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_param_core: PARITY must be 0, 1 or 2");
  end
  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8) begin : g_bad_oversample
    $error("uart_param_core: OVERSAMPLE must be even and at least 8");
  end

  // Parity bit for a payload: even -> XOR of data, odd -> its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    if (PARITY == 1) begin
      parity_bit = ~(^d);
    end else begin
      parity_bit = ^d;
    end
  endfunction

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_e;

  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 tick_s;
  logic                 rx_meta_q, rx_sync_q;

  tx_state_e            tx_state_q, tx_state_d;
  logic [BIT_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic [3:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_q, tx_d;
  logic                 tx_ready_q, tx_ready_d;
  logic                 tx_bit_end_s;

  rx_state_e            rx_state_q, rx_state_d;
  logic [OS_W-1:0]      rx_tcnt_q, rx_tcnt_d;
  logic [3:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_low_seen_q, rx_low_seen_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_center_s;

  // Free-running oversample tick divider.
  always_comb begin
    if (div_cnt_q == DIV_W'(DIV - 1)) begin
      tick_s    = 1'b1;
      div_cnt_d = '0;
    end else begin
      tick_s    = 1'b0;
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // Tick divider and rx double-flop synchroniser (line idles high).
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // TX next state. TX times bits in whole clocks so every bit, including the
  // start bit launched on the handshake edge, lasts exactly OVERSAMPLE ticks.
  always_comb begin
    tx_state_d   = tx_state_q;
    tx_idx_d     = tx_idx_q;
    tx_shift_d   = tx_shift_q;
    tx_par_d     = tx_par_q;
    tx_d         = tx_q;
    tx_ready_d   = tx_ready_q;
    tx_bit_end_s = (tx_cnt_q == BIT_W'(BIT_CLKS - 1));
    if (tx_state_q == TX_IDLE || tx_bit_end_s) begin
      tx_cnt_d = '0;
    end else begin
      tx_cnt_d = tx_cnt_q + 1'b1;
    end
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.tx_valid && tx_ready_q) begin
          tx_shift_d = bus.tx_data;
          tx_par_d   = parity_bit(bus.tx_data);
          tx_d       = 1'b0;
          tx_ready_d = 1'b0;
          tx_state_d = TX_START;
        end else begin
          tx_d       = 1'b1;
          tx_ready_d = 1'b1;
        end
      end
      TX_START: begin
        if (tx_bit_end_s) begin
          tx_d       = tx_shift_q[0];
          tx_idx_d   = 4'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_d = 1'b0;
        end
      end
      TX_DATA: begin
        if (tx_bit_end_s) begin
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          if (tx_idx_q == 4'(DATA_BITS - 1)) begin
            tx_idx_d = 4'd0;
            if (PARITY != 0) begin
              tx_d       = tx_par_q;
              tx_state_d = TX_PARITY;
            end else begin
              tx_d       = 1'b1;
              tx_state_d = TX_STOP;
            end
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
            tx_d     = tx_shift_q[1];
          end
        end else begin
          tx_d = tx_q;
        end
      end
      TX_PARITY: begin
        if (tx_bit_end_s) begin
          tx_d       = 1'b1;
          tx_idx_d   = 4'd0;
          tx_state_d = TX_STOP;
        end else begin
          tx_d = tx_q;
        end
      end
      TX_STOP: begin
        if (tx_bit_end_s && tx_idx_q == 4'(STOP_BITS - 1)) begin
          tx_ready_d = 1'b1;
          tx_state_d = TX_IDLE;
        end else if (tx_bit_end_s) begin
          tx_idx_d = tx_idx_q + 1'b1;
        end else begin
          tx_d = 1'b1;
        end
      end
      default: begin
        tx_d       = 1'b1;
        tx_ready_d = 1'b1;
        tx_state_d = TX_IDLE;
      end
    endcase
  end

  // TX state register; tx and tx_ready come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= 4'd0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
      tx_ready_q <= tx_ready_d;
    end
  end

  // RX next state: every sample point is a whole bit after the start-bit centre.
  always_comb begin
    rx_state_d    = rx_state_q;
    rx_tcnt_d     = rx_tcnt_q;
    rx_idx_d      = rx_idx_q;
    rx_shift_d    = rx_shift_q;
    rx_par_d      = rx_par_q;
    rx_low_seen_d = rx_low_seen_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    rx_ferr_d     = rx_ferr_q;
    rx_perr_d     = rx_perr_q;
    rx_center_s   = tick_s && (rx_tcnt_q == OS_W'(OVERSAMPLE - 1));
    if (tick_s && !rx_center_s) begin
      rx_tcnt_d = rx_tcnt_q + 1'b1;
    end else if (rx_center_s) begin
      rx_tcnt_d = '0;
    end else begin
      rx_tcnt_d = rx_tcnt_q;
    end
    case (rx_state_q)
      RX_IDLE: begin
        rx_tcnt_d = '0;
        if (tick_s && !rx_sync_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        // Half a bit after detection: a high line here means a glitch.
        if (tick_s && rx_tcnt_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
          rx_tcnt_d = '0;
          rx_idx_d  = 4'd0;
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
          end
        end else begin
          rx_state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_center_s) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          if (rx_idx_q == 4'(DATA_BITS - 1)) begin
            rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
          end else begin
            rx_idx_d = rx_idx_q + 1'b1;
          end
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      RX_PARITY: begin
        if (rx_center_s) begin
          rx_par_d   = rx_sync_q;
          rx_state_d = RX_STOP;
        end else begin
          rx_state_d = RX_PARITY;
        end
      end
      RX_STOP: begin
        if (rx_center_s) begin
          rx_valid_d    = 1'b1;
          rx_data_d     = rx_shift_q;
          rx_ferr_d     = ~rx_sync_q;
          rx_perr_d     = (PARITY != 0) && (rx_par_q != parity_bit(rx_shift_q));
          rx_low_seen_d = 1'b1;
          rx_state_d    = rx_sync_q ? RX_IDLE : RX_WAIT_IDLE;
        end else begin
          rx_state_d = RX_STOP;
        end
      end
      RX_WAIT_IDLE: begin
        // Leave only after a whole tick interval with the line high.
        if (tick_s) begin
          rx_low_seen_d = ~rx_sync_q;
          rx_state_d    = (!rx_low_seen_q && rx_sync_q) ? RX_IDLE : RX_WAIT_IDLE;
        end else begin
          rx_low_seen_d = rx_low_seen_q | ~rx_sync_q;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // RX state register and registered receive outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q    <= RX_IDLE;
      rx_tcnt_q     <= '0;
      rx_idx_q      <= 4'd0;
      rx_shift_q    <= '0;
      rx_par_q      <= 1'b0;
      rx_low_seen_q <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      rx_ferr_q     <= 1'b0;
      rx_perr_q     <= 1'b0;
    end else begin
      rx_state_q    <= rx_state_d;
      rx_tcnt_q     <= rx_tcnt_d;
      rx_idx_q      <= rx_idx_d;
      rx_shift_q    <= rx_shift_d;
      rx_par_q      <= rx_par_d;
      rx_low_seen_q <= rx_low_seen_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      rx_ferr_q     <= rx_ferr_d;
      rx_perr_q     <= rx_perr_d;
    end
  end

  assign tx                = tx_q;
  assign bus.tx_ready      = tx_ready_q;
  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_frame_err  = rx_ferr_q;
  assign bus.rx_parity_err = rx_perr_q;
endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core. Line rate is scaled down (DIV=4, OVERSAMPLE=8,
// 32 clocks per bit) so that full frames fit a short run. Three cores:
// 8N1 (loopback capable), even parity and odd parity.
module tb_uart_param_core;
  localparam int BIT = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_param_core_if #(.DATA_BITS(8)) if0 ();
  uart_param_core_if #(.DATA_BITS(8)) ife ();
  uart_param_core_if #(.DATA_BITS(8)) ifo ();

  logic tx0, tx_e, tx_o;
  logic rx_drv0 = 1'b1;
  logic rx_drv_e = 1'b1;
  logic rx_idle_o = 1'b1;
  logic loop_en = 1'b0;
  logic line0;
  assign line0 = loop_en ? tx0 : rx_drv0;

  uart_param_core #(.CLK_FREQ(3200000), .BAUD(100000), .OVERSAMPLE(8),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0), .tx(tx0), .rx(line0));
  uart_param_core #(.CLK_FREQ(3200000), .BAUD(100000), .OVERSAMPLE(8),
                    .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    dut_e (.clk(clk), .rst(rst), .bus(ife), .tx(tx_e), .rx(rx_drv_e));
  uart_param_core #(.CLK_FREQ(3200000), .BAUD(100000), .OVERSAMPLE(8),
                    .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    dut_o (.clk(clk), .rst(rst), .bus(ifo), .tx(tx_o), .rx(rx_idle_o));

  int tests = 0;
  int fails = 0;

  // Received-frame logs: {frame_err, parity_err, data}
  logic [9:0] log0[$];
  logic [9:0] log_e[$];
  always @(negedge clk) begin
    if (if0.rx_valid) log0.push_back({if0.rx_frame_err, if0.rx_parity_err, if0.rx_data});
    if (ife.rx_valid) log_e.push_back({ife.rx_frame_err, ife.rx_parity_err, ife.rx_data});
  end

  typedef struct {
    int         sel;     // 0 = 8N1, 1 = even, 2 = odd
    logic [7:0] data;
    int         nbits;
    logic [10:0] frame;  // bit k = k-th bit on the line
  } tx_vec_t;

  typedef struct {
    logic [10:0] frame;
    logic [7:0]  data;
    logic        perr;
  } rx_vec_t;

  tx_vec_t tx_vecs[6];
  rx_vec_t rx_vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int sel, input logic valid, input logic [7:0] data);
    case (sel)
      0: begin if0.tx_valid = valid; if0.tx_data = data; end
      1: begin ife.tx_valid = valid; ife.tx_data = data; end
      default: begin ifo.tx_valid = valid; ifo.tx_data = data; end
    endcase
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      0: return tx0;
      1: return tx_e;
      default: return tx_o;
    endcase
  endfunction

  function automatic logic get_ready(input int sel);
    case (sel)
      0: return if0.tx_ready;
      1: return ife.tx_ready;
      default: return ifo.tx_ready;
    endcase
  endfunction

  // One transmit frame: check each bit at its centre and the exact tx_ready return.
  task automatic run_tx_vec(input tx_vec_t v, input int idx);
    logic early;
    early = 1'b0;
    @(negedge clk);
    check($sformatf("tx%0d_ready_idle", idx), get_ready(v.sel), 1);
    set_in(v.sel, 1'b1, v.data);
    @(negedge clk);
    set_in(v.sel, 1'b0, ~v.data);  // must not disturb the frame in flight
    check($sformatf("tx%0d_ready_drop", idx), get_ready(v.sel), 0);
    check($sformatf("tx%0d_start_now", idx), get_tx(v.sel), 0);
    for (int i = 1; i <= v.nbits * BIT; i++) begin
      @(negedge clk);
      if (i % BIT == BIT / 2)
        check($sformatf("tx%0d_bit%0d", idx, i / BIT), get_tx(v.sel), v.frame[i / BIT]);
      if (i < v.nbits * BIT && get_ready(v.sel)) early = 1'b1;
    end
    check($sformatf("tx%0d_ready_early", idx), early, 0);
    check($sformatf("tx%0d_ready_back", idx), get_ready(v.sel), 1);
    check($sformatf("tx%0d_idle_high", idx), get_tx(v.sel), 1);
  endtask

  // Drive a frame onto rx line sel (0 = 8N1 core, 1 = even core); line left at last bit.
  task automatic send_line(input int sel, input logic [10:0] frame, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      if (sel == 0) rx_drv0 = frame[k]; else rx_drv_e = frame[k];
      repeat (BIT) @(negedge clk);
    end
  endtask

  logic [7:0] bytes[50];
  int         starts[50];

  initial begin
    tx_vecs[0] = '{0, 8'h55, 10, {1'b0, 1'b1, 8'h55, 1'b0}};
    tx_vecs[1] = '{0, 8'h0F, 10, {1'b0, 1'b1, 8'h0F, 1'b0}};
    tx_vecs[2] = '{1, 8'hA5, 11, {1'b1, 1'b0, 8'hA5, 1'b0}};
    tx_vecs[3] = '{2, 8'hA5, 11, {1'b1, 1'b1, 8'hA5, 1'b0}};
    tx_vecs[4] = '{1, 8'h01, 11, {1'b1, 1'b1, 8'h01, 1'b0}};
    tx_vecs[5] = '{2, 8'h01, 11, {1'b1, 1'b0, 8'h01, 1'b0}};
    rx_vecs[0] = '{{1'b1, 1'b0, 8'hA5, 1'b0}, 8'hA5, 1'b0};
    rx_vecs[1] = '{{1'b1, 1'b1, 8'hA5, 1'b0}, 8'hA5, 1'b1};
    rx_vecs[2] = '{{1'b1, 1'b1, 8'h01, 1'b0}, 8'h01, 1'b0};
    rx_vecs[3] = '{{1'b1, 1'b0, 8'h01, 1'b0}, 8'h01, 1'b1};

    set_in(0, 1'b0, 8'h00);
    set_in(1, 1'b0, 8'h00);
    set_in(2, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    check("rst_tx", tx0, 1);
    check("rst_ready", if0.tx_ready, 1);
    check("rst_rx_valid", if0.rx_valid, 0);
    check("rst_rx_data", if0.rx_data, 0);
    check("rst_flags", {if0.rx_frame_err, if0.rx_parity_err}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Transmit frames on all three formats.
    for (int n = 0; n < 6; n++) run_tx_vec(tx_vecs[n], n);

    // Parity checking on the even-parity receiver.
    for (int n = 0; n < 4; n++) begin
      log_e.delete();
      send_line(1, rx_vecs[n].frame, 11);
      rx_drv_e = 1'b1;
      repeat (BIT) @(negedge clk);
      check($sformatf("rxp%0d_count", n), log_e.size(), 1);
      if (log_e.size() > 0) begin
        check($sformatf("rxp%0d_data", n), log_e[0][7:0], rx_vecs[n].data);
        check($sformatf("rxp%0d_perr", n), log_e[0][8], rx_vecs[n].perr);
        check($sformatf("rxp%0d_ferr", n), log_e[0][9], 0);
      end
    end

    // Short glitch is rejected, then a clean 0x3C frame is received.
    log0.delete();
    rx_drv0 = 1'b0;
    repeat (6) @(negedge clk);
    rx_drv0 = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("glitch_no_valid", log0.size(), 0);
    send_line(0, {1'b0, 1'b1, 8'h3C, 1'b0}, 10);
    rx_drv0 = 1'b1;
    repeat (BIT) @(negedge clk);
    check("glitch_next_count", log0.size(), 1);
    if (log0.size() > 0) check("glitch_next_frame", log0[0], {2'b00, 8'h3C});

    // Frame error followed by a held-low line (break).
    log0.delete();
    send_line(0, {1'b0, 1'b0, 8'h81, 1'b0}, 10);
    repeat (3 * BIT) @(negedge clk);
    check("ferr_count", log0.size(), 1);
    if (log0.size() > 0) check("ferr_frame", log0[0], {2'b10, 8'h81});
    rx_drv0 = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check("ferr_no_repeat", log0.size(), 1);
    send_line(0, {1'b0, 1'b1, 8'h42, 1'b0}, 10);
    rx_drv0 = 1'b1;
    repeat (BIT) @(negedge clk);
    check("ferr_recover_count", log0.size(), 2);
    if (log0.size() > 1) check("ferr_recover_frame", log0[1], {2'b00, 8'h42});

    // Loopback of 50 bytes with tx_valid held high.
    begin
      int sent, guard, cyc, gap_bad;
      logic prev_ready;
      for (int n = 0; n < 50; n++) bytes[n] = 8'($urandom_range(127, 32));
      log0.delete();
      loop_en = 1'b1;
      sent = 0; guard = 0; cyc = 0; gap_bad = 0;
      @(negedge clk);
      prev_ready = if0.tx_ready;
      set_in(0, 1'b1, bytes[0]);
      while (sent < 50 && guard < 20000) begin
        @(negedge clk);
        cyc++; guard++;
        if (prev_ready && !if0.tx_ready) begin
          starts[sent] = cyc;
          sent++;
          if (sent < 50) set_in(0, 1'b1, bytes[sent]);
          else set_in(0, 1'b0, 8'h00);
        end
        prev_ready = if0.tx_ready;
      end
      check("loop_sent", sent, 50);
      // Ready returns 10 bits after start; the next frame launches on the following edge.
      for (int n = 1; n < sent; n++)
        if (starts[n] - starts[n-1] != 10 * BIT + 1) gap_bad++;
      check("loop_gap_bad", gap_bad, 0);
      repeat (11 * BIT) @(negedge clk);
      check("loop_count", log0.size(), 50);
      begin
        int bad = 0;
        for (int n = 0; n < 50 && n < log0.size(); n++)
          if (log0[n] !== {2'b00, bytes[n]}) bad++;
        check("loop_data_bad", bad, 0);
      end
    end

    // Reset during the 4th data bit aborts TX and discards the partial RX frame.
    log0.delete();
    @(negedge clk);
    set_in(0, 1'b1, 8'h55);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00);
    repeat (4 * BIT + BIT / 2 - 1) @(negedge clk);
    check("mid_tx_is_data", tx0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", tx0, 1);
    check("mid_rst_ready", if0.tx_ready, 1);
    check("mid_rst_rx_data", if0.rx_data, 0);
    rst = 1'b0;
    repeat (12 * BIT) @(negedge clk);
    check("mid_rst_no_valid", log0.size(), 0);
    check("mid_rst_tx_idle", tx0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
